vec_mac: RTL and testbench

- Parametrised, pipelined multi-lane multiply-accumulate engine computing a signed dot product over a runtime-programmed number of beats.
- Each beat multiplies LANES operand pairs, reduces them through a registered adder tree and accumulates the sum.
- Selectable wrap or saturate overflow handling; valid/ready handshakes on both input and result.
- Next-generation replacement for the single-lane MAC inside the matrix-multiplier datapath; one instance per output element.

---
 rtl/mac_pkg.sv | 48 ++++
 rtl/mac_adder_tree.sv | 52 +++++
 rtl/vec_mac.sv | 179 +++++++++++++++++
 tb/tb_vec_mac.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the vec_mac dot-product engine and its sub-blocks:
//   - mac_state_e  : control FSM encoding (IDLE / RUN / DRAIN / HOLD)
//   - sat_max()    : most positive two's-complement value of a given width
//   - sat_min()    : most negative two's-complement value of a given width
//   - ovf_detect() : signed-add overflow from the operand and result MSBs
// ---------------------------------------------------------------------------
package mac_pkg;

   // Upper bound on accumulator widths the saturation helpers can describe.
   localparam int unsigned SAT_W_MAX = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } mac_state_e;

   // Low 'width' bits hold 0111...1; callers truncate to their own width.
   function automatic logic [SAT_W_MAX-1:0] sat_max(input int unsigned width);
      logic [SAT_W_MAX-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < SAT_W_MAX; i++) begin
         if (i + 1 < width) r[i] = 1'b1;
      end
      return r;
   endfunction

   // Low 'width' bits hold 1000...0; callers truncate to their own width.
   function automatic logic [SAT_W_MAX-1:0] sat_min(input int unsigned width);
      logic [SAT_W_MAX-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < SAT_W_MAX; i++) begin
         if (i + 1 == width) r[i] = 1'b1;
      end
      return r;
   endfunction

   // Overflow: both addends share a sign and the sum's sign differs from it.
   function automatic logic ovf_detect(input logic a_msb,
                                       input logic b_msb,
                                       input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// ---------------------------------------------------------------------------
// mac_adder_tree
// Registered reduction of LANES signed 2*DATA_WIDTH-bit products into one
// signed sum of 2*DATA_WIDTH+$clog2(LANES) bits (wide enough that the sum
// can never overflow). One register stage; valid travels with the data.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : products on in_prod are meaningful
//   in_prod    : packed products, lane i = [i*2*DATA_WIDTH +: 2*DATA_WIDTH]
//   out_valid  : out_sum holds the reduction of a valid product set
//   out_sum    : registered signed sum
// ---------------------------------------------------------------------------
module mac_adder_tree #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned LANES      = 4
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            in_valid,
   input  logic [LANES*2*DATA_WIDTH-1:0]                   in_prod,
   output logic                                            out_valid,
   output logic [2*DATA_WIDTH+$clog2(LANES)-1:0]           out_sum
);

   localparam int unsigned PW = 2*DATA_WIDTH;
   localparam int unsigned SW = PW + $clog2(LANES);

   logic signed [SW-1:0] sum_d, sum_q;
   logic                 valid_d, valid_q;

   always_comb begin
      sum_d   = '0;
      valid_d = in_valid;
      for (int unsigned i = 0; i < LANES; i++) begin
         sum_d = sum_d + SW'($signed(in_prod[i*PW +: PW]));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         valid_q <= valid_d;
      end
   end

   assign out_sum   = sum_q;
   assign out_valid = valid_q;

endmodule

// File: rtl/vec_mac.sv
// ---------------------------------------------------------------------------
// vec_mac
// Pipelined multi-lane signed multiply-accumulate computing a dot product
// over a runtime-programmed number of beats, with wrap or saturate overflow.
//   stage 1 : LANES full-precision products (registered)
//   stage 2 : adder-tree sum (mac_adder_tree, registered)
//   stage 3 : sign-extend and accumulate into total
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, beats, sat_en: begin a dot product (honoured only in IDLE)
//   in_valid / in_ready : operand beat handshake (in_ready = RUN)
//   in_a, in_b          : packed signed operands, lane i = [i*DW +: DW]
//   out_valid/out_ready : result handshake (out_valid = HOLD)
//   total, err          : signed result and sticky overflow flag
//   busy                : engine not idle
// ---------------------------------------------------------------------------
module vec_mac
   import mac_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned LANES       = 4,
   parameter int unsigned ACCUM_WIDTH = 2*DATA_WIDTH + $clog2(LANES) + 8,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [CNT_WIDTH-1:0]          beats,
   input  logic                          sat_en,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*DATA_WIDTH-1:0]   in_a,
   input  logic [LANES*DATA_WIDTH-1:0]   in_b,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ACCUM_WIDTH-1:0]        total,
   output logic                          err,
   output logic                          busy
);

   localparam int unsigned PW = 2*DATA_WIDTH;
   localparam int unsigned SW = PW + $clog2(LANES);

   localparam logic [ACCUM_WIDTH-1:0] ACC_MAX = ACCUM_WIDTH'(sat_max(ACCUM_WIDTH));
   localparam logic [ACCUM_WIDTH-1:0] ACC_MIN = ACCUM_WIDTH'(sat_min(ACCUM_WIDTH));

   mac_state_e               state_d, state_q;
   logic [CNT_WIDTH-1:0]     cnt_d, cnt_q;
   logic                     sat_d, sat_q;
   logic [ACCUM_WIDTH-1:0]   total_d, total_q;
   logic                     err_d, err_q;

   logic [LANES*PW-1:0]      prod_d, prod_q;
   logic                     s1_valid_d, s1_valid_q;

   logic                     s2_valid;
   logic [SW-1:0]            s2_sum;

   logic                     accept;
   logic [ACCUM_WIDTH-1:0]   sum_ext;
   logic [ACCUM_WIDTH-1:0]   acc_raw;
   logic                     acc_ovf;

   assign accept = (state_q == RUN) && in_valid;

   // ---------------- stage 1: lane products ----------------
   always_comb begin
      prod_d     = prod_q;
      s1_valid_d = accept;
      if (accept) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            prod_d[i*PW +: PW] = PW'($signed(in_a[i*DATA_WIDTH +: DATA_WIDTH]))
                               * PW'($signed(in_b[i*DATA_WIDTH +: DATA_WIDTH]));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_q     <= '0;
         s1_valid_q <= 1'b0;
      end else begin
         prod_q     <= prod_d;
         s1_valid_q <= s1_valid_d;
      end
   end

   // ---------------- stage 2: adder tree ----------------
   mac_adder_tree #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES)
   ) u_tree (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (s1_valid_q),
      .in_prod    (prod_q),
      .out_valid  (s2_valid),
      .out_sum    (s2_sum)
   );

   // ---------------- stage 3 + control ----------------
   assign sum_ext = ACCUM_WIDTH'($signed(s2_sum));
   assign acc_raw = total_q + sum_ext;
   assign acc_ovf = ovf_detect(total_q[ACCUM_WIDTH-1], sum_ext[ACCUM_WIDTH-1],
                               acc_raw[ACCUM_WIDTH-1]);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      total_d = total_q;
      err_d   = err_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               sat_d   = sat_en;
               total_d = '0;
               err_d   = 1'b0;
               if (beats != '0) begin
                  cnt_d   = beats;
                  state_d = RUN;
               end else begin
                  state_d = HOLD;
               end
            end
         end
         RUN: begin
            if (accept) begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
               if (cnt_q == CNT_WIDTH'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Both pipe stages empty means the final accumulate already landed.
            if (!s1_valid_q && !s2_valid) state_d = HOLD;
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // The pipe is always empty in IDLE, so this never races the start clear.
      if (s2_valid) begin
         if (acc_ovf) begin
            err_d = 1'b1;
            // Operand sign tells which rail was crossed.
            if (sat_q) total_d = total_q[ACCUM_WIDTH-1] ? ACC_MIN : ACC_MAX;
            else       total_d = acc_raw;
         end else begin
            total_d = acc_raw;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         total_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         total_q <= total_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == RUN);
   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q != IDLE);
   assign total     = total_q;
   assign err       = err_q;

endmodule

// File: tb/tb_vec_mac.sv
// ---------------------------------------------------------------------------
// tb_vec_mac
// Directed bench for vec_mac (ACCUM_WIDTH=34). Stimulus pushes the expected
// {err,total} per dot product into a queue; a monitor compares every cycle
// a result is presented and pops on the out_ready handshake.
// ---------------------------------------------------------------------------
module tb_vec_mac;

   localparam int unsigned DW = 16;
   localparam int unsigned LN = 4;
   localparam int unsigned AW = 34;
   localparam int unsigned CW = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [CW-1:0]     beats = '0;
   logic              sat_en = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [LN*DW-1:0]  in_a = '0;
   logic [LN*DW-1:0]  in_b = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [AW-1:0]     total;
   logic              err;
   logic              busy;

   int checks = 0;
   int errors = 0;

   logic [AW:0] exp_q[$];   // {err, total}

   vec_mac #(
      .DATA_WIDTH  (DW),
      .LANES       (LN),
      .ACCUM_WIDTH (AW),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .beats     (beats),
      .sat_en    (sat_en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .total     (total),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic logic [LN*DW-1:0] pack4(input int v0, input int v1,
                                             input int v2, input int v3);
      logic [LN*DW-1:0] r;
      r[0*DW +: DW] = DW'(v0);
      r[1*DW +: DW] = DW'(v1);
      r[2*DW +: DW] = DW'(v2);
      r[3*DW +: DW] = DW'(v3);
      return r;
   endfunction

   // All driving happens 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n, input logic s);
      beats  = CW'(n);
      sat_en = s;
      start  = 1'b1;
      step();
      start  = 1'b0;
   endtask

   task automatic send_beat(input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b);
      int k;
      k = 0;
      while (!in_ready && k < 20) begin
         step();
         k++;
      end
      if (k == 20) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got 0 expected 1 (t=%0t)", $time);
      end
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         step();
         cyc++;
      end
      if (!out_valid) begin
         checks++;
         errors++;
         $display("FAIL out_valid_timeout: got 0 expected 1 (t=%0t)", $time);
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 40) begin
         step();
         k++;
      end
      chk("return_to_idle", 64'(busy), 64'(0));
   endtask

   // Scoreboard monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got total %0h err %0b expected none (t=%0t)",
                        total, err, $time);
            end else begin
               chk("result_total", 64'(total), 64'(exp_q[0][AW-1:0]));
               chk("result_err",   64'(err),   64'(exp_q[0][AW]));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LN*DW-1:0] neg_max;
      int cyc;

      neg_max = pack4(-32768, -32768, -32768, -32768);

      // Reset state.
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready",  64'(in_ready),  64'(0));
      chk("rst_busy",      64'(busy),      64'(0));
      chk("rst_total",     64'(total),     64'(0));
      chk("rst_err",       64'(err),       64'(0));
      step();
      step();
      rst = 1'b0;
      step();

      // Basic: 70 + (-40) = 30, back-to-back beats.
      do_start(2, 1'b0);
      chk("run_in_ready", 64'(in_ready), 64'(1));
      exp_q.push_back({1'b0, AW'(30)});
      send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
      send_beat(pack4(-1, -1, -1, -1), pack4(10, 10, 10, 10));
      wait_out(cyc);
      chk("latency_cycles", 64'(cyc), 64'(3));
      wait_idle();

      // Gaps and result hold.
      out_ready = 1'b0;
      do_start(2, 1'b0);
      exp_q.push_back({1'b0, AW'(30)});
      send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
      step();
      step();
      send_beat(pack4(-1, -1, -1, -1), pack4(10, 10, 10, 10));
      wait_out(cyc);
      chk("gap_latency_cycles", 64'(cyc), 64'(3));
      for (int i = 0; i < 5; i++) begin
         chk("hold_in_ready",  64'(in_ready),  64'(0));
         chk("hold_out_valid", 64'(out_valid), 64'(1));
         chk("hold_busy",      64'(busy),      64'(1));
         if (i == 2) begin
            beats = CW'(1);
            start = 1'b1;
         end
         step();
         start = 1'b0;
      end
      out_ready = 1'b1;
      beats     = CW'(1);
      start     = 1'b1;   // coincident with the handshake: must be ignored
      step();
      start     = 1'b0;
      chk("post_hold_out_valid", 64'(out_valid), 64'(0));
      chk("post_hold_busy",      64'(busy),      64'(0));
      step();
      chk("start_ignored_busy",     64'(busy),     64'(0));
      chk("start_ignored_in_ready", 64'(in_ready), 64'(0));

      // Saturation: 2^32 + 2^32 clamps to 2^33-1.
      do_start(2, 1'b1);
      exp_q.push_back({1'b1, 34'h1FFFFFFFF});
      send_beat(neg_max, neg_max);
      send_beat(neg_max, neg_max);
      wait_out(cyc);
      wait_idle();

      // Wrap: 2^33 wraps to -2^33.
      do_start(2, 1'b0);
      exp_q.push_back({1'b1, 34'h200000000});
      send_beat(neg_max, neg_max);
      send_beat(neg_max, neg_max);
      wait_out(cyc);
      wait_idle();

      // Next start clears total and err.
      do_start(1, 1'b0);
      chk("restart_err_cleared", 64'(err), 64'(0));
      exp_q.push_back({1'b0, AW'(0)});
      send_beat('0, '0);
      wait_out(cyc);
      wait_idle();

      // Zero-length dot product.
      do_start(0, 1'b0);
      exp_q.push_back({1'b0, AW'(0)});
      chk("zero_out_valid", 64'(out_valid), 64'(1));
      chk("zero_in_ready",  64'(in_ready),  64'(0));
      wait_idle();

      // Reset mid-run after 1 of 3 beats.
      do_start(3, 1'b0);
      send_beat(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2));
      step();
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_total",     64'(total),     64'(0));
      chk("midrst_err",       64'(err),       64'(0));
      chk("midrst_busy",      64'(busy),      64'(0));
      chk("midrst_in_ready",  64'(in_ready),  64'(0));
      step();
      step();
      rst = 1'b0;
      step();
      do_start(1, 1'b0);
      exp_q.push_back({1'b0, AW'(8)});
      send_beat(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2));
      wait_out(cyc);
      chk("post_rst_latency", 64'(cyc), 64'(3));
      wait_idle();

      step();
      step();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
